// File: rtl/cpu_step_ctrl_pkg.sv
// Shared types and constants for the CPU step controller.
package cpu_step_ctrl_pkg;

    localparam int DIV_BASE_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        RUN     = 2'd2,
        HALTED  = 2'd3
    } step_state_t;

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// Button/mode inputs and step/status outputs of the CPU step controller.
interface cpu_step_ctrl_if;

    logic       btn_raw;
    logic       run_mode;
    logic [2:0] rate_sel;
    logic       halt;
    logic       step;
    logic       btn_clean;
    logic [1:0] state_o;
    logic       halted;
    logic [7:0] step_count;

    modport master (
        output btn_raw, run_mode, rate_sel, halt,
        input  step, btn_clean, state_o, halted, step_count
    );

    modport slave (
        input  btn_raw, run_mode, rate_sel, halt,
        output step, btn_clean, state_o, halted, step_count
    );

endinterface

// File: rtl/cpu_step_ctrl_debounce.sv
// Two-flop synchronizer followed by a stability counter; btn_clean only
// follows the synchronized button after DEBOUNCE_CYCLES disagreeing samples.
module cpu_step_ctrl_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DEB_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_clean
);

    logic             sync_a;
    logic             btn_sync;
    logic [DEB_W-1:0] cnt;
    logic [DEB_W-1:0] cnt_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a   <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            sync_a   <= btn_raw;
            btn_sync <= sync_a;
        end
    end

    assign cnt_inc = cnt + DEB_W'(1);

    // Any sample agreeing with btn_clean restarts the count, so short glitches vanish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            btn_clean <= 1'b0;
        end else if (btn_sync == btn_clean) begin
            cnt <= '0;
        end else if (cnt_inc == DEB_W'(DEBOUNCE_CYCLES)) begin
            btn_clean <= btn_sync;
            cnt       <= '0;
        end else begin
            cnt <= cnt_inc;
        end
    end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Turns the activate button into one-cycle step enables for the core, in
// single-step or periodic run mode, stopping while the core reports halt.
module cpu_step_ctrl
    import cpu_step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DEB_W           = 20,
    parameter int RUN_SHIFT       = 0
) (
    input  logic            clk,
    input  logic            rst,
    cpu_step_ctrl_if.slave  bus
);

    localparam int DIV_W = DIV_BASE_W + RUN_SHIFT;

    step_state_t      state;
    step_state_t      state_next;
    logic             btn_clean;
    logic             clean_prev;
    logic             press;
    logic             step_q;
    logic             step_next;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_next;
    logic [DIV_W-1:0] interval_last;
    logic [7:0]       count;

    cpu_step_ctrl_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DEB_W           (DEB_W)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (bus.btn_raw),
        .btn_clean (btn_clean)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clean_prev <= 1'b0;
        end else begin
            clean_prev <= btn_clean;
        end
    end

    assign press         = btn_clean & ~clean_prev;
    assign interval_last = (DIV_W'(1) << (int'(bus.rate_sel) + RUN_SHIFT)) - DIV_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.run_mode)          state_next = RUN;
                else if (press && bus.halt) state_next = HALTED;
                else if (press)            state_next = PRESSED;
            end
            PRESSED: begin
                if (bus.run_mode)  state_next = RUN;
                else if (!btn_clean) state_next = IDLE;
            end
            RUN: begin
                if (!bus.run_mode) state_next = IDLE;
                else if (bus.halt) state_next = HALTED;
            end
            HALTED: begin
                if (!bus.run_mode && !bus.halt && !btn_clean) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The divider is held at zero outside RUN, which gives the clear-on-entry behaviour;
    // the >= compare lets a shortened interval fire immediately.
    always_comb begin
        step_next = 1'b0;
        div_next  = '0;
        case (state)
            IDLE: begin
                step_next = !bus.run_mode && press && !bus.halt;
            end
            RUN: begin
                if (bus.run_mode && !bus.halt) begin
                    if (div >= interval_last) begin
                        step_next = 1'b1;
                    end else begin
                        div_next = div + DIV_W'(1);
                    end
                end
            end
            default: begin
                step_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q <= 1'b0;
            div    <= '0;
            count  <= 8'd0;
        end else begin
            step_q <= step_next;
            div    <= div_next;
            count  <= count + {7'd0, step_q};
        end
    end

    assign bus.step       = step_q;
    assign bus.btn_clean  = btn_clean;
    assign bus.state_o    = state;
    assign bus.halted     = (state == HALTED);
    assign bus.step_count = count;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench: a cycle model predicts each step, a monitor pops and compares.
module tb_cpu_step_ctrl;

    localparam int DEB      = 4;
    localparam int S_IDLE   = 0;
    localparam int S_PRESS  = 1;
    localparam int S_RUN    = 2;
    localparam int S_HALTED = 3;

    bit clk = 1'b0;
    bit rst = 1'b1;

    cpu_step_ctrl_if bus();

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .DEB_W           (20),
        .RUN_SHIFT       (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int passes = 0;

    int unsigned m_cyc    = 0;
    int unsigned m_anchor = 0;
    bit          m_s1     = 1'b0;
    bit          m_s2     = 1'b0;
    bit          m_clean  = 1'b0;
    bit          m_prev   = 1'b0;
    bit          m_step   = 1'b0;
    int          m_streak = 0;
    int          m_mode   = S_IDLE;
    bit [7:0]    m_count  = 8'd0;
    int unsigned exp_q[$];

    bit       r_raw;
    bit       r_run;
    bit [2:0] r_rate;
    bit       r_halt;
    int       r_len;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, m_cyc);
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".btn_clean"}, int'(bus.btn_clean), int'(m_clean));
        checkOutput({tag, ".state"}, int'(bus.state_o), m_mode);
        checkOutput({tag, ".halted"}, int'(bus.halted), int'(m_mode == S_HALTED));
        checkOutput({tag, ".step_count"}, int'(bus.step_count), int'(m_count));
    endtask

    task automatic applyStimulus(input bit raw, input bit run, input bit [2:0] rate,
                                 input bit hlt, input int cycles);
        bus.btn_raw  = raw;
        bus.run_mode = run;
        bus.rate_sel = rate;
        bus.halt     = hlt;
        repeat (cycles) begin
            @(posedge clk);
            #3;
        end
    endtask

    // One clock edge of the reference behaviour, using the values held before the edge.
    task automatic modelEdge();
        bit press;
        bit fire;
        int unsigned interval;
        press    = m_clean && !m_prev;
        interval = 32'd1 << bus.rate_sel;
        fire     = 1'b0;
        m_count  = m_count + 8'(m_step);
        case (m_mode)
            S_IDLE: begin
                if (bus.run_mode) begin m_mode = S_RUN; m_anchor = m_cyc; end
                else if (press && bus.halt) m_mode = S_HALTED;
                else if (press) begin fire = 1'b1; m_mode = S_PRESS; end
            end
            S_PRESS: begin
                if (bus.run_mode) begin m_mode = S_RUN; m_anchor = m_cyc; end
                else if (!m_clean) m_mode = S_IDLE;
            end
            S_RUN: begin
                if (!bus.run_mode) m_mode = S_IDLE;
                else if (bus.halt) m_mode = S_HALTED;
                else if (m_cyc - m_anchor >= interval) begin fire = 1'b1; m_anchor = m_cyc; end
            end
            default: begin
                if (!bus.run_mode && !bus.halt && !m_clean) m_mode = S_IDLE;
            end
        endcase
        m_step = fire;
        if (fire) exp_q.push_back(m_cyc);
        m_prev   = m_clean;
        m_streak = (m_s2 != m_clean) ? m_streak + 1 : 0;
        if (m_streak == DEB) begin
            m_clean  = m_s2;
            m_streak = 0;
        end
        m_s2 = m_s1;
        m_s1 = bus.btn_raw;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_clean = 1'b0; m_prev = 1'b0;
            m_step = 1'b0; m_streak = 0; m_mode = S_IDLE; m_count = 8'd0;
            exp_q.delete();
        end else begin
            m_cyc++;
            modelEdge();
        end
    end

    initial forever begin
        bit exp_hit;
        @(negedge clk);
        if (!rst) begin
            exp_hit = (exp_q.size() > 0) && (exp_q[0] == m_cyc);
            if (exp_hit) void'(exp_q.pop_front());
            if (bus.step || exp_hit) checkOutput("step", int'(bus.step), int'(exp_hit));
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.btn_raw = 1'b0; bus.run_mode = 1'b0; bus.rate_sel = 3'd0; bus.halt = 1'b0;
        for (int i = 0; i < 6; i++) applyStimulus(i[0], 1'b0, 3'd0, 1'b0, 1);
        checkOutput("reset.step", int'(bus.step), 0);
        checkOutput("reset.btn_clean", int'(bus.btn_clean), 0);
        checkOutput("reset.state", int'(bus.state_o), S_IDLE);
        checkOutput("reset.halted", int'(bus.halted), 0);
        checkOutput("reset.step_count", int'(bus.step_count), 0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 2);
        checkOutput("post_reset.state", int'(bus.state_o), S_IDLE);
        checkOutput("post_reset.step_count", int'(bus.step_count), 0);

        $display("[TB] glitch filtering");
        applyStimulus(1, 0, 0, 0, 2);
        applyStimulus(0, 0, 0, 0, 10);
        checkOutput("glitch.btn_clean", int'(bus.btn_clean), 0);
        checkOutput("glitch.step_count", int'(bus.step_count), 0);
        applyStimulus(1, 0, 0, 0, 10);
        applyStimulus(0, 0, 0, 0, 20);
        checkOutput("press10.step_count", int'(bus.step_count), 1);
        checkModel("press10");

        $display("[TB] hold and repeated presses");
        applyStimulus(1, 0, 0, 0, 200);
        checkOutput("hold.step_count", int'(bus.step_count), 2);
        applyStimulus(0, 0, 0, 0, 10);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 0, 0, 8);
            applyStimulus(0, 0, 0, 0, 8);
        end
        checkOutput("presses.step_count", int'(bus.step_count), 7);
        checkModel("presses");

        $display("[TB] run mode");
        applyStimulus(0, 1, 2, 0, 41);
        applyStimulus(0, 0, 2, 0, 3);
        checkOutput("run.step_count", int'(bus.step_count), 17);
        checkModel("run");

        $display("[TB] halt handling");
        applyStimulus(0, 1, 1, 0, 10);
        applyStimulus(0, 1, 1, 1, 20);
        checkOutput("run_halt.halted", int'(bus.halted), 1);
        checkModel("run_halt");
        applyStimulus(0, 0, 1, 0, 3);
        checkOutput("unhalt.state", int'(bus.state_o), S_IDLE);
        applyStimulus(1, 0, 0, 1, 10);
        applyStimulus(0, 0, 0, 1, 10);
        checkOutput("press_halt.state", int'(bus.state_o), S_HALTED);
        checkModel("press_halt");
        applyStimulus(0, 0, 0, 0, 3);
        checkModel("release_halt");

        $display("[TB] press coinciding with run_mode");
        applyStimulus(1, 0, 2, 0, 1);
        for (int i = 0; i < 20 && !m_clean; i++) applyStimulus(1, 0, 2, 0, 1);
        checkOutput("clean_wait", int'(bus.btn_clean), 1);
        applyStimulus(1, 1, 2, 0, 3);
        checkOutput("press_run.state", int'(bus.state_o), S_RUN);
        checkModel("press_run");
        applyStimulus(1, 1, 2, 0, 10);
        rst = 1'b1;
        applyStimulus(1, 1, 2, 0, 1);
        checkOutput("rst_run.step_count", int'(bus.step_count), 0);
        checkOutput("rst_run.state", int'(bus.state_o), S_IDLE);
        rst = 1'b0;
        applyStimulus(1, 0, 2, 0, 12);
        checkOutput("held_reset.step_count", int'(bus.step_count), 1);
        applyStimulus(0, 0, 2, 0, 10);
        checkModel("held_reset");

        $display("[TB] step_count wrap");
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 2);
        rst = 1'b0;
        applyStimulus(0, 1, 0, 0, 258);
        applyStimulus(0, 0, 0, 0, 3);
        checkOutput("wrap.step_count", int'(bus.step_count), 1);

        $display("[TB] randomized traffic");
        r_raw = 1'b0; r_run = 1'b0; r_rate = 3'd0; r_halt = 1'b0;
        for (int seg = 0; seg < 150; seg++) begin
            r_raw  = ($urandom_range(0, 2) == 0) ? !r_raw : r_raw;
            r_run  = ($urandom_range(0, 4) == 0) ? !r_run : r_run;
            r_rate = 3'($urandom_range(0, 3));
            r_halt = ($urandom_range(0, 7) == 0);
            r_len  = int'($urandom_range(1, 12));
            if ($urandom_range(0, 60) == 0) begin
                rst = 1'b1;
                applyStimulus(r_raw, r_run, r_rate, r_halt, 1);
                rst = 1'b0;
            end
            for (int c = 0; c < r_len; c++) begin
                applyStimulus(r_raw, r_run, r_rate, r_halt, 1);
                checkModel("rand");
            end
        end
        applyStimulus(0, 0, 0, 0, 20);
        checkModel("final");
        checkOutput("pending_steps", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
